// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory bus port between instruction fetch (IF) and
//             data access (MEM). Arbitrates (MEM has priority), runs a
//             single-outstanding valid/ready command + response handshake,
//             and returns one-cycle completion pulses to the requesters.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                       clock, synchronous active-high reset
//    mem_port_arbiter_if_*          fetch request/address/kill, instr word out
//    mem_port_arbiter_fetched_ok_o  fetch-complete pulse
//    mem_port_arbiter_mem_*         data request/we/addr/wdata/wstrb, rdata out
//    mem_port_arbiter_access_ok_o   data-complete pulse
//    mem_port_arbiter_bus_*         command (valid/ready) and response channel
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                mem_port_arbiter_if_req_i,
  input  logic [ADDR_W-1:0]   mem_port_arbiter_if_addr_i,
  input  logic                mem_port_arbiter_if_kill_i,
  output logic [31:0]         mem_port_arbiter_if_rdata_o,
  output logic                mem_port_arbiter_fetched_ok_o,
  // data access side
  input  logic                mem_port_arbiter_mem_req_i,
  input  logic                mem_port_arbiter_mem_we_i,
  input  logic [ADDR_W-1:0]   mem_port_arbiter_mem_addr_i,
  input  logic [DATA_W-1:0]   mem_port_arbiter_mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_port_arbiter_mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_port_arbiter_mem_rdata_o,
  output logic                mem_port_arbiter_access_ok_o,
  // bus side
  output logic                mem_port_arbiter_bus_valid_o,
  input  logic                mem_port_arbiter_bus_ready_i,
  output logic                mem_port_arbiter_bus_we_o,
  output logic [ADDR_W-1:0]   mem_port_arbiter_bus_addr_o,
  output logic [DATA_W-1:0]   mem_port_arbiter_bus_wdata_o,
  output logic [DATA_W/8-1:0] mem_port_arbiter_bus_wstrb_o,
  input  logic                mem_port_arbiter_bus_resp_i,
  input  logic [DATA_W-1:0]   mem_port_arbiter_bus_rdata_i
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  logic [1:0]          r_state;
  logic                r_own_mem;   // 1 = data access owns the bus, 0 = fetch
  logic                r_word_sel;  // fetch PC bit 2: upper/lower half of bus word
  logic                r_kill;      // in-flight fetch has been redirected away
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [31:0]         r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;

  logic                w_fetch_grant;
  logic                w_unused;

  // A fetch that is already being killed this cycle must not be started.
  assign w_fetch_grant = mem_port_arbiter_if_req_i & ~mem_port_arbiter_if_kill_i;

  // Instruction fetches are always 4-byte aligned; bits [1:0] carry no info.
  assign w_unused = ^mem_port_arbiter_if_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_own_mem   <= 1'b0;
      r_word_sel  <= 1'b0;
      r_kill      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_kill <= 1'b0;
          if (mem_port_arbiter_mem_req_i) begin
            // Data access belongs to the older instruction, so it wins.
            r_own_mem <= 1'b1;
            r_we      <= mem_port_arbiter_mem_we_i;
            r_addr    <= mem_port_arbiter_mem_addr_i;
            r_wdata   <= mem_port_arbiter_mem_wdata_i;
            r_wstrb   <= mem_port_arbiter_mem_we_i ? mem_port_arbiter_mem_wstrb_i : '0;
            r_state   <= c_ST_REQ;
          end else if (w_fetch_grant) begin
            r_own_mem  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= {mem_port_arbiter_if_addr_i[ADDR_W-1:3], 3'b000};
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_word_sel <= mem_port_arbiter_if_addr_i[2];
            r_state    <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          if (mem_port_arbiter_bus_ready_i) begin
            r_state <= c_ST_WAIT;
          end
          if (!r_own_mem && mem_port_arbiter_if_kill_i) begin
            r_kill <= 1'b1;
          end
        end
        c_ST_WAIT: begin
          if (mem_port_arbiter_bus_resp_i) begin
            if (r_own_mem) begin
              r_mem_rdata <= mem_port_arbiter_bus_rdata_i;
            end else begin
              r_if_rdata <= r_word_sel ? mem_port_arbiter_bus_rdata_i[63:32]
                                       : mem_port_arbiter_bus_rdata_i[31:0];
            end
            r_state <= c_ST_DONE;
          end
          if (!r_own_mem && mem_port_arbiter_if_kill_i) begin
            r_kill <= 1'b1;
          end
        end
        default: begin
          // DONE: no grant here so requesters get a cycle to drop req.
          // A kill arriving now is handled combinationally on the pulse.
          r_kill  <= 1'b0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign mem_port_arbiter_bus_valid_o  = (r_state == c_ST_REQ);
  assign mem_port_arbiter_bus_we_o     = r_we;
  assign mem_port_arbiter_bus_addr_o   = r_addr;
  assign mem_port_arbiter_bus_wdata_o  = r_wdata;
  assign mem_port_arbiter_bus_wstrb_o  = r_wstrb;

  assign mem_port_arbiter_if_rdata_o   = r_if_rdata;
  assign mem_port_arbiter_mem_rdata_o  = r_mem_rdata;

  assign mem_port_arbiter_access_ok_o  = (r_state == c_ST_DONE) & r_own_mem;
  assign mem_port_arbiter_fetched_ok_o = (r_state == c_ST_DONE) & ~r_own_mem
                                       & ~r_kill & ~mem_port_arbiter_if_kill_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [63:0]       if_addr;
  logic              if_kill;
  logic [31:0]       if_rdata;
  logic              fetched_ok;
  logic              mem_req;
  logic              mem_we;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic [63:0]       mem_rdata;
  logic              access_ok;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [63:0]       bus_addr;
  logic [63:0]       bus_wdata;
  logic [7:0]        bus_wstrb;
  logic              bus_resp;
  logic [63:0]       bus_rdata;

  int n_chk;
  int n_fail;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk                           (clk),
    .rst                           (rst),
    .mem_port_arbiter_if_req_i     (if_req),
    .mem_port_arbiter_if_addr_i    (if_addr),
    .mem_port_arbiter_if_kill_i    (if_kill),
    .mem_port_arbiter_if_rdata_o   (if_rdata),
    .mem_port_arbiter_fetched_ok_o (fetched_ok),
    .mem_port_arbiter_mem_req_i    (mem_req),
    .mem_port_arbiter_mem_we_i     (mem_we),
    .mem_port_arbiter_mem_addr_i   (mem_addr),
    .mem_port_arbiter_mem_wdata_i  (mem_wdata),
    .mem_port_arbiter_mem_wstrb_i  (mem_wstrb),
    .mem_port_arbiter_mem_rdata_o  (mem_rdata),
    .mem_port_arbiter_access_ok_o  (access_ok),
    .mem_port_arbiter_bus_valid_o  (bus_valid),
    .mem_port_arbiter_bus_ready_i  (bus_ready),
    .mem_port_arbiter_bus_we_o     (bus_we),
    .mem_port_arbiter_bus_addr_o   (bus_addr),
    .mem_port_arbiter_bus_wdata_o  (bus_wdata),
    .mem_port_arbiter_bus_wstrb_o  (bus_wstrb),
    .mem_port_arbiter_bus_resp_i   (bus_resp),
    .mem_port_arbiter_bus_rdata_i  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full minimum-latency fetch: req in cycle N, valid N+1, resp N+2, ok N+3.
  task automatic do_fetch(input string tag, input logic [63:0] addr,
                          input logic [63:0] rd, input logic [31:0] exp_word);
    if_req  = 1'b1;
    if_addr = addr;
    tick();                                                   // N+1 (REQ)
    check({tag, "_valid"}, bus_valid, 1);
    check({tag, "_addr"},  bus_addr,  {addr[63:3], 3'b000});
    check({tag, "_wstrb"}, bus_wstrb, 0);
    tick();                                                   // N+2 (WAIT)
    bus_resp  = 1'b1;
    bus_rdata = rd;
    tick();                                                   // N+3 (DONE)
    bus_resp  = 1'b0;
    check({tag, "_fok"},   fetched_ok, 1);
    check({tag, "_rdata"}, if_rdata,   exp_word);
    if_req = 1'b0;
    tick();                                                   // N+4 (IDLE)
    check({tag, "_fok_low"}, fetched_ok, 0);
    check({tag, "_idle"},    bus_valid,  0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    if_kill   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    bus_ready = 1'b1;
    bus_resp  = 1'b0;
    bus_rdata = '0;
    repeat (3) tick();

    // ---- reset state
    check("rst_valid", bus_valid,  0);
    check("rst_we",    bus_we,     0);
    check("rst_addr",  bus_addr,   0);
    check("rst_wdata", bus_wdata,  0);
    check("rst_wstrb", bus_wstrb,  0);
    check("rst_ifrd",  if_rdata,   0);
    check("rst_memrd", mem_rdata,  0);
    check("rst_fok",   fetched_ok, 0);
    check("rst_aok",   access_ok,  0);
    rst = 1'b0;
    tick();

    // ---- single fetch, upper word selected
    do_fetch("f1", 64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);

    // ---- simultaneous requests: MEM load first, then fetch
    if_req   = 1'b1;
    if_addr  = 64'h8000_0010;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 64'h8000_1008;
    mem_wdata = 64'h0123_4567_89AB_CDEF;
    mem_wstrb = 8'hFF;
    tick();                                                   // N+1
    check("sim_valid1", bus_valid, 1);
    check("sim_addr1",  bus_addr,  64'h8000_1008);
    check("sim_we1",    bus_we,    0);
    check("sim_wstrb1", bus_wstrb, 0);
    tick();                                                   // N+2
    bus_resp  = 1'b1;
    bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();                                                   // N+3
    bus_resp = 1'b0;
    check("sim_aok",    access_ok,  1);
    check("sim_fok_n3", fetched_ok, 0);
    check("sim_memrd",  mem_rdata,  64'hAAAA_BBBB_CCCC_DDDD);
    mem_req = 1'b0;
    tick();                                                   // N+4 IDLE
    check("sim_valid4", bus_valid, 0);
    check("sim_aok4",   access_ok, 0);
    tick();                                                   // N+5
    check("sim_valid5", bus_valid, 1);
    check("sim_addr5",  bus_addr,  64'h8000_0010);
    check("sim_we5",    bus_we,    0);
    check("sim_wstrb5", bus_wstrb, 0);
    tick();                                                   // N+6
    bus_resp  = 1'b1;
    bus_rdata = 64'h5555_6666_7777_8888;
    tick();                                                   // N+7
    bus_resp = 1'b0;
    check("sim_fok",    fetched_ok, 1);
    check("sim_ifrd",   if_rdata,   32'h7777_8888);
    check("sim_memhold", mem_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    if_req = 1'b0;
    tick();

    // ---- store with 3 cycles of backpressure
    bus_ready = 1'b0;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 64'h8000_2000;
    mem_wdata = 64'h0000_0000_DEAD_BEEF;
    mem_wstrb = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus_ready = 1'b1;
      check("st_valid", bus_valid, 1);
      check("st_we",    bus_we,    1);
      check("st_addr",  bus_addr,  64'h8000_2000);
      check("st_wdata", bus_wdata, 64'h0000_0000_DEAD_BEEF);
      check("st_wstrb", bus_wstrb, 8'h0F);
      check("st_aok",   access_ok, 0);
    end
    tick();                                                   // WAIT
    check("st_valid_off", bus_valid, 0);
    bus_resp  = 1'b1;
    bus_rdata = 64'h0;
    tick();                                                   // DONE
    bus_resp = 1'b0;
    check("st_aok_done", access_ok, 1);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    tick();
    check("st_aok_after", access_ok, 0);

    // ---- kill during WAIT
    if_req  = 1'b1;
    if_addr = 64'h8000_0020;
    tick();                                                   // REQ
    check("kw_valid", bus_valid, 1);
    tick();                                                   // WAIT
    if_kill = 1'b1;
    if_req  = 1'b0;
    tick();                                                   // still WAIT
    if_kill   = 1'b0;
    bus_resp  = 1'b1;
    bus_rdata = 64'h9999_9999_9999_9999;
    tick();                                                   // DONE
    bus_resp = 1'b0;
    check("kw_fok", fetched_ok, 0);
    tick();                                                   // IDLE
    check("kw_fok_idle", fetched_ok, 0);
    check("kw_valid_idle", bus_valid, 0);
    do_fetch("f2", 64'h8000_0028, 64'hCAFE_F00D_1234_5678, 32'h1234_5678);

    // ---- kill in the DONE cycle suppresses that pulse
    if_req  = 1'b1;
    if_addr = 64'h8000_0030;
    tick();
    tick();
    bus_resp  = 1'b1;
    bus_rdata = 64'h0;
    tick();                                                   // DONE
    bus_resp = 1'b0;
    if_kill  = 1'b1;
    #1;
    check("kd_fok", fetched_ok, 0);
    if_req  = 1'b0;
    if_kill = 1'b0;
    tick();

    // ---- kill in IDLE with request high: no grant
    if_req  = 1'b1;
    if_kill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ki_valid", bus_valid, 0);
    end
    if_req  = 1'b0;
    if_kill = 1'b0;
    tick();

    // ---- reset in WAIT, then stale response
    mem_req  = 1'b1;
    mem_we   = 1'b1;
    mem_addr = 64'h8000_3000;
    mem_wdata = 64'h1;
    mem_wstrb = 8'hFF;
    tick();                                                   // REQ
    tick();                                                   // WAIT
    rst = 1'b1;
    tick();
    check("rm_valid", bus_valid, 0);
    check("rm_we",    bus_we,    0);
    check("rm_addr",  bus_addr,  0);
    check("rm_wdata", bus_wdata, 0);
    check("rm_wstrb", bus_wstrb, 0);
    check("rm_ifrd",  if_rdata,  0);
    rst      = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    bus_resp = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus_resp = 1'b0;
    check("rm_aok",   access_ok, 0);
    check("rm_valid2", bus_valid, 0);
    tick();
    check("rm_aok2",  access_ok, 0);
    check("rm_memrd", mem_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
